// File: rtl/input_port_io_pkg.sv
// Shared IO constants: register offsets, SW_BIN bit positions, converter
// state encoding and the BCD helpers used by the input responder.
package input_port_io_pkg;

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_LEVEL  = 2'd1;
  localparam logic [1:0] OFF_SW_RAW = 2'd2;
  localparam logic [1:0] OFF_SW_BIN = 2'd3;

  localparam int SWB_VALID = 16;
  localparam int SWB_ERR   = 17;
  localparam int SWB_BUSY  = 18;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  typedef struct packed {
    logic [13:0] value;
    logic        valid;
    logic        err;
  } sw_bin_t;

  function automatic logic [13:0] mac10(input logic [13:0] acc, input logic [3:0] digit);
    return (acc * 14'd10) + {10'd0, digit};
  endfunction

  function automatic logic bcd_err(input logic [15:0] v);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) begin
        e = 1'b1;
      end else begin
        e = e;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/input_port_io_debounce_sync.sv
// Two-flop synchroniser followed by a debouncer whose WIDTH bits share one
// mismatch counter; the whole group takes the synchronised value together.
module debounce_sync #(
  parameter int WIDTH     = 1,
  parameter int DB_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  localparam logic [3:0] DB_LIMIT = 4'(DB_CYCLES);

  logic [WIDTH-1:0] s1_q, s2_q, lvl_q, lvl_d;
  logic [3:0]       cnt_q, cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = 4'd0;
    if (s2_q != lvl_q) begin
      if (cnt_q + 4'd1 == DB_LIMIT) begin
        lvl_d = s2_q;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      cnt_q <= 4'd0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  // Rise is flagged on the same edge that the debounced level goes high.
  assign level = lvl_q;
  assign rise  = lvl_d & ~lvl_q;

endmodule

// File: rtl/input_port_io.sv
// Memory-mapped input responder: debounced buttons with sticky W1C press
// flags, and debounced BCD switches converted to binary by a small FSM.
module input_port_io
  import input_port_io_pkg::*;
#(
  parameter int NBTN      = 4,
  parameter int DB_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  input  logic [15:0]     sw_raw,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [NBTN-1:0] btn_lvl_s, btn_rise_s, clr_s, status_q, status_d;
  logic [15:0]     sw_lvl_s, snap_q, snap_d;
  logic [13:0]     acc_q, acc_d, mac_s;
  logic [3:0]      digit_s;
  logic [1:0]      k_q, k_d;
  logic [0:0]      state_q, state_d;
  logic            busy_q, busy_d;
  sw_bin_t         bin_q, bin_d;
  logic            unused_wdata_s;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    debounce_sync #(.WIDTH(1), .DB_CYCLES(DB_CYCLES)) u_btn (
      .clk(clk), .reset(reset), .din(btn_raw[g]),
      .level(btn_lvl_s[g]), .rise(btn_rise_s[g])
    );
  end

  logic [15:0] sw_rise_unused;
  debounce_sync #(.WIDTH(16), .DB_CYCLES(DB_CYCLES)) u_sw (
    .clk(clk), .reset(reset), .din(sw_raw),
    .level(sw_lvl_s), .rise(sw_rise_unused)
  );

  assign unused_wdata_s = ^wdata[31:NBTN];

  // A new press outranks a simultaneous W1C of the same bit.
  always_comb begin
    clr_s    = (sel && we && (addr == OFF_STATUS)) ? wdata[NBTN-1:0] : {NBTN{1'b0}};
    status_d = (status_q & ~clr_s) | btn_rise_s;
  end

  assign digit_s = snap_q[{k_q, 2'b00} +: 4];
  assign mac_s   = mac10(acc_q, digit_s);

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    k_d     = k_q;
    busy_d  = busy_q;
    bin_d   = bin_q;
    case (state_q)
      ST_IDLE: begin
        if (sw_lvl_s != snap_q) begin
          snap_d  = sw_lvl_s;
          acc_d   = 14'd0;
          k_d     = 2'd3;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        acc_d = mac_s;
        if (k_q == 2'd0) begin
          if (bcd_err(snap_q)) begin
            bin_d = '{value: 14'd0, valid: 1'b0, err: 1'b1};
          end else begin
            bin_d = '{value: mac_s, valid: 1'b1, err: 1'b0};
          end
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          k_d = k_q - 2'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= {NBTN{1'b0}};
      state_q  <= ST_IDLE;
      snap_q   <= 16'd0;
      acc_q    <= 14'd0;
      k_q      <= 2'd0;
      busy_q   <= 1'b0;
      bin_q    <= '{value: 14'd0, valid: 1'b1, err: 1'b0};
    end else begin
      status_q <= status_d;
      state_q  <= state_d;
      snap_q   <= snap_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      bin_q    <= bin_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr)
        OFF_STATUS: rdata[NBTN-1:0] = status_q;
        OFF_LEVEL:  rdata[NBTN-1:0] = btn_lvl_s;
        OFF_SW_RAW: rdata[15:0]     = sw_lvl_s;
        OFF_SW_BIN: begin
          rdata[13:0]      = bin_q.value;
          rdata[SWB_VALID] = bin_q.valid;
          rdata[SWB_ERR]   = bin_q.err;
          rdata[SWB_BUSY]  = busy_q;
        end
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: doc/input_port_io.md
# input_port_io

Memory-mapped input responder for the single-cycle RISC-V FPGA system. It sits on the data-memory bus beside the output ports and serves the other direction: it turns raw board buttons and switches into CPU-readable registers. Buttons are synchronised and debounced, and each press is latched into sticky, write-1-to-clear flags. The 4-digit BCD switch value is converted to binary by a multi-cycle sequential converter, so firmware gets a ready binary operand without software conversion.

## Interface
Parameters:
- NBTN, 4: number of buttons.
- DB_CYCLES, 3: consecutive stable cycles needed before a debounced level changes (1..15).

Ports:
- clk  in  1  system clock (the divided CPU clock); all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NBTN  asynchronous button inputs, 1 = pressed.
- sw_raw  in  16  asynchronous switches, four BCD digits, [15:12] most significant.
- sel  in  1  bus select, decoded externally from the address.
- addr  in  2  word offset, byte address bits [3:2].
- we  in  1  write strobe, qualified by sel.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from registers; 0 when sel=0.

## Operation
Register map (offset by addr):
- 0 STATUS: [NBTN-1:0] sticky press flags. Write 1 to clear a bit; write 0 has no effect.
- 1 LEVEL: [NBTN-1:0] debounced button levels. Read-only.
- 2 SW_RAW: [15:0] debounced switch value. Read-only.
- 3 SW_BIN: [13:0] binary value; [16] valid; [17] err (a digit > 9); [18] busy. Read-only.

Unused bits read as 0. Writes to read-only offsets are ignored.

Input path:
- Each input passes through a 2-flop synchroniser.
- Per-bit debounce: a counter holds the count of cycles in which the synchronised value differs from the debounced level. A match resets the counter. When the counter reaches DB_CYCLES, the debounced level takes the synchronised value.
- Debounced switches form one 16-bit group with a single shared counter. Any difference counts; the group updates as a whole.
- A press sets the matching STATUS bit in the same cycle the debounced level rises 0→1. A release does not set it.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.

Converter FSM:
- States are IDLE and CONV.
- In IDLE, if the debounced switches differ from the snapshot: load the snapshot, set acc=0 and k=3, set busy=1, and go to CONV.
- Each CONV cycle: acc ← acc*10 + digit[k]. Width is 14 bits, and the maximum is 9999, which fits.
- After the cycle with k=0: write SW_BIN.
  - Normal result: valid=1, err=0.
  - If any digit > 9: value=0, err=1, valid=0.
  - Then busy=0 and return to IDLE.
- Switch changes during CONV do not abort the conversion. The mismatch is picked up in IDLE on the next cycle, which restarts the conversion.

## Timing
Reset values:
- Synchronisers, debounced levels, debounce counters, STATUS, snapshot, acc: 0.
- SW_BIN value 0, valid=1, err=0, busy=0. This is consistent with the switches reading 0.
- FSM in IDLE.

Latencies:
- Raw edge → debounced level: 2 cycles of sync + DB_CYCLES. With defaults that is 5 cycles, and STATUS is set in the same cycle.
- A glitch shorter than DB_CYCLES cycles after synchronisation is never seen.
- Debounced switch change → SW_BIN updated: 5 cycles. That is 1 cycle to load, then 4 CONV cycles, and the result is readable at the next edge.
- A write takes effect at the clock edge where sel & we is high. A read in the same cycle returns the value before the write.
- busy is visible in rdata from the cycle after the load through the last CONV cycle.

## Structure
- Register offsets, SW_BIN bit positions and the FSM state encoding belong in the shared io constants package used by the other IO blocks.
- The debounce logic is one natural sub-module, `debounce_sync`, with parameters WIDTH and DB_CYCLES. It is instantiated once for the buttons (per bit) and once for the switch group.

## Test plan
- Reset: read all four offsets → STATUS=0, LEVEL=0, SW_RAW=0, SW_BIN=0x0001_0000.
- Assert btn_raw[1] and hold for 10 cycles → LEVEL[1]=1 and STATUS[1]=1 exactly 5 cycles after the edge. Write 0x2 to STATUS → it reads 0 while LEVEL stays 1.
- Pulse btn_raw[0] for 2 cycles → LEVEL and STATUS stay 0.
- Set sw_raw=0x1234 and hold → SW_RAW=0x1234, then busy high, then SW_BIN[13:0]=1234 with valid=1. Also check sw_raw=0x9999 → 9999.
- Set sw_raw=0x12A4 → SW_BIN value 0, err=1, valid=0.
- Hold STATUS[2] set, then write W1C in the same cycle as a new debounced press of button 2 → STATUS[2] remains 1.
- Change switches from 0x0005 to 0x0007 during CONV → the first result is 5, then a reconversion starts automatically and gives a final value of 7.
